// File: rtl/uart_rx_write_ram_if.sv
// RAM write bus carried from the UART receive/assembler block to a 64x16 RAM.
//   write_enable_to_ram : one-cycle write strobe
//   address_to_ram      : 6-bit word address (held during the strobe)
//   data_to_ram         : 16-bit write data {high_byte, low_byte}
// master = the block producing writes, slave = the RAM (or an observer).
interface uart_rx_write_ram_if;
  logic        write_enable_to_ram;
  logic [5:0]  address_to_ram;
  logic [15:0] data_to_ram;

  modport master (
    output write_enable_to_ram,
    output address_to_ram,
    output data_to_ram
  );

  modport slave (
    input write_enable_to_ram,
    input address_to_ram,
    input data_to_ram
  );
endinterface

// File: rtl/uart_rx_write_ram.sv
// UART 8N1 receiver that pairs received bytes into 16-bit words (high byte
// first) and writes them to sequential addresses of a 64-word RAM. A byte
// equal to eoe, arriving where a high byte is expected, ends the frame.
// Ports:
//   clk         : system clock, rising edge
//   reset       : asynchronous active-high reset
//   uart_RX     : asynchronous serial input, idle high
//   eoe         : end-of-entry marker byte, static during a frame
//   ram         : RAM write bus (master side)
//   done        : sticky, frame terminated by eoe
//   overflow    : sticky, address wrapped within the current frame
//   frame_error : one-cycle pulse, stop bit sampled low
module uart_rx_write_ram #(
  parameter int BAUD_DIV = 10416
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       uart_RX,
  input  logic [7:0]                 eoe,
  uart_rx_write_ram_if.master        ram,
  output logic                       done,
  output logic                       overflow,
  output logic                       frame_error
);

  localparam int TW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;
  localparam logic [TW-1:0] FULL_LAST = TW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'((BAUD_DIV / 2) - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // Synchroniser
  logic rx_meta_r;
  logic rx_sync_r;

  // Receiver state
  rx_state_t     state_r, state_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [2:0]    bit_idx_r, bit_idx_s;
  logic [7:0]    shift_r, shift_s;
  logic [7:0]    rx_byte_r, rx_byte_s;
  logic          byte_valid_r, byte_valid_s;
  logic          frame_err_r, frame_err_s;

  // Assembler state
  logic          phase_r;
  logic [7:0]    high_r;
  logic          we_r;
  logic [5:0]    addr_r;
  logic [15:0]   data_r;
  logic          done_r;
  logic          overflow_r;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_RX;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receiver state register; byte_valid and frame_error are registered pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      timer_r      <= '0;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      rx_byte_r    <= 8'h00;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      timer_r      <= timer_s;
      bit_idx_r    <= bit_idx_s;
      shift_r      <= shift_s;
      rx_byte_r    <= rx_byte_s;
      byte_valid_r <= byte_valid_s;
      frame_err_r  <= frame_err_s;
    end
  end

  // Receiver next-state: start is checked at mid-bit, data/stop one bit apart.
  always_comb begin
    state_s      = state_r;
    timer_s      = timer_r + TW'(1);
    bit_idx_s    = bit_idx_r;
    shift_s      = shift_r;
    rx_byte_s    = rx_byte_r;
    byte_valid_s = 1'b0;
    frame_err_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        timer_s = '0;
        if (rx_sync_r == 1'b0) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (timer_r == HALF_LAST) begin
          timer_s   = '0;
          bit_idx_s = 3'd0;
          // A line back high at mid-start-bit was only a glitch.
          if (rx_sync_r == 1'b0) begin
            state_s = ST_DATA;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (timer_r == FULL_LAST) begin
          timer_s = '0;
          shift_s = {rx_sync_r, shift_r[7:1]};  // LSB arrives first
          if (bit_idx_r == 3'd7) begin
            state_s = ST_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (timer_r == FULL_LAST) begin
          timer_s = '0;
          // Back to IDLE at mid-stop so an early next start edge is not missed.
          state_s = ST_IDLE;
          if (rx_sync_r == 1'b1) begin
            byte_valid_s = 1'b1;
            rx_byte_s    = shift_r;
          end else begin
            frame_err_s = 1'b1;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        timer_s = '0;
      end
    endcase
  end

  // Word assembler and address counter; eoe only counts in the high-byte slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_r    <= 1'b0;
      high_r     <= 8'h00;
      we_r       <= 1'b0;
      addr_r     <= 6'd0;
      data_r     <= 16'h0000;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      we_r <= 1'b0;
      if (we_r) begin
        addr_r <= addr_r + 6'd1;  // wraps 63 -> 0 naturally
        if (addr_r == 6'd63) begin
          overflow_r <= 1'b1;
        end
      end
      if (byte_valid_r) begin
        if (phase_r == 1'b0) begin
          if (rx_byte_r == eoe) begin
            done_r     <= 1'b1;
            addr_r     <= 6'd0;
            overflow_r <= 1'b0;
          end else begin
            high_r  <= rx_byte_r;
            done_r  <= 1'b0;
            phase_r <= 1'b1;
          end
        end else begin
          data_r  <= {high_r, rx_byte_r};
          we_r    <= 1'b1;
          phase_r <= 1'b0;
        end
      end
    end
  end

  assign ram.write_enable_to_ram = we_r;
  assign ram.address_to_ram      = addr_r;
  assign ram.data_to_ram         = data_r;
  assign done                    = done_r;
  assign overflow                = overflow_r;
  assign frame_error             = frame_err_r;

endmodule

// File: doc/uart_rx_write_ram.md
# uart_rx_write_ram

Receive-side counterpart of the RAM-to-UART transmit path. The block deserialises 8N1 UART bytes from the serial input and pairs them into 16-bit words, high byte first. It writes each word into a 64-word RAM at sequential addresses. A configurable end-of-entry byte (`eoe`) terminates a frame, so a host can load the RAM that the transmit path later reads back.

## Interface
- `BAUD_DIV`, 10416: clock cycles per UART bit (100 MHz / 9600 baud); must be ≥ 4.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `uart_RX` in 1: asynchronous serial input; idle high.
- `eoe` in 8: end-of-entry marker byte; static during a frame.
- `write_enable_to_ram` out 1: one-cycle RAM write strobe.
- `address_to_ram` out 6: RAM word address.
- `data_to_ram` out 16: RAM write data, `{high_byte, low_byte}`.
- `done` out 1: sticky; frame terminated by `eoe`.
- `overflow` out 1: sticky; address wrapped within the current frame.
- `frame_error` out 1: one-cycle pulse; stop bit sampled low.

## Operation
- Synchroniser: 2-FF synchroniser on `uart_RX`; both flops reset to 1. All receiver logic uses the synchronised bit `rx_s`.
- Receiver FSM (IDLE, START, DATA, STOP); a bit-timer counts to `BAUD_DIV-1`.
  - IDLE: on `rx_s` == 0, go to START and clear the timer.
  - START: after `BAUD_DIV/2` cycles (mid-start-bit), sample `rx_s`. If 0, go to DATA with timer cleared and bit index 0. If 1, it was a glitch; return to IDLE with no output.
  - DATA: every `BAUD_DIV` cycles, sample `rx_s` into shift register, LSB first. After bit index 7, go to STOP.
  - STOP: after `BAUD_DIV` cycles (mid-stop-bit), sample. If 1, raise internal `byte_valid` for one cycle with `rx_byte`. If 0, pulse `frame_error` and discard the byte. Both cases return to IDLE immediately, so a start edge arriving in the second half of the stop bit is caught.
- Assembler, using a `byte_phase` flag (reset 0), runs on `byte_valid`:
  - Phase 0, `rx_byte == eoe`:
    - Set `done`.
    - Reset address to 0 and clear `overflow`.
    - No write; phase stays 0.
  - Phase 0, any other byte:
    - Latch the high byte.
    - Clear `done`.
    - Set phase to 1.
  - Phase 1, any byte (including a value equal to `eoe`, which is data here):
    - Drive `data_to_ram = {high, rx_byte}`.
    - Assert `write_enable_to_ram` for one cycle.
    - Set phase to 0.
- Address: increments by 1 in the cycle after each write. A write at address 63 wraps the address to 0 and sets `overflow`; data keeps being written from address 0.
- A frame error does not change `byte_phase`, the address, or `done`.
- Reset mid-byte or mid-word: everything returns to the reset state, and the partial byte or word is lost. After reset the receiver waits in IDLE for the next falling edge; a line held low after reset is treated as a start bit.

## Timing
- Reset values:
  - `write_enable_to_ram` 0, `address_to_ram` 0, `data_to_ram` 0.
  - `done` 0, `overflow` 0, `frame_error` 0.
  - Receiver FSM in IDLE.
- Receiver latency: mid-stop sample lands about 2 + `BAUD_DIV/2` + 9·`BAUD_DIV` cycles after the falling edge on `uart_RX`.
- `byte_valid` follows the stop sample by 1 cycle.
- Write timing:
  - `write_enable_to_ram` and `data_to_ram` become valid 1 cycle after `byte_valid`, i.e. registered.
  - `address_to_ram` holds the write address during the strobe and increments the following cycle.
  - `data_to_ram` holds its value until the next write.
- `done` rises in the same cycle a write strobe would have occurred.
- `frame_error` rises 1 cycle after the stop sample.
- Back-to-back bytes with zero idle time are sustained; the assembler needs 1 cycle per byte, far below the ~5000-cycle stop-bit slack.

## Test plan
All scenarios use `BAUD_DIV` = 16 and `eoe` = 0x0A.
1. Send bytes 0x12, 0x34 -> one `write_enable_to_ram` pulse with address 0 and data 0x1234. Address becomes 1; `done` stays 0.
2. Send 0xAB, 0xCD, 0x0A -> write 0xABCD at address 0. Then `done` = 1 and address = 0, with no second write.
3. Send 0x55, 0x0A -> write 0x550A at address 0; `done` stays 0 (`eoe` in phase 1 is data).
4. Send a byte whose stop bit is forced to 0 -> one-cycle `frame_error`, no write. A following 0x01, 0x02 then writes 0x0102 at address 0.
5. Send 65 two-byte words -> 64 writes at addresses 0..63. `overflow` = 1 after the 64th write; the 65th word goes to address 0.
6. Send a 3-cycle low glitch on `uart_RX` -> no byte and no error. Separately, assert `reset` in the middle of the second byte of a word -> all outputs 0; a subsequent 0x77, 0x88 writes 0x7788 at address 0.
